// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser
// Payout back-end of the vending machine. It accepts a change amount over a
// valid/ready handshake and pays it out greedily, one coin at a time, Rs.10 coins
// first and then Rs.5 coins. It tracks how many coins of each kind the hopper
// holds. If the inventory or the amount cannot settle the full sum, it reports a
// shortfall and the unpaid residue.
//
// Optional feature: define VEND_ACK_TIMEOUT_EN to add a hopper-ack watchdog.
// After 15 PAY cycles without coin_ack_i, the offered coin is withdrawn and not
// deducted. The request then finishes short, with the remaining amount as residue.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   req_valid_i    change request present
//   req_amount_i   change in rupees, 0..31
//   req_ready_o    block can accept a request (idle and no refill)
//   refill_i       reload both inventories to their INIT values (honoured in idle only)
//   coin_valid_o   a coin is offered to the hopper
//   coin_is_ten_o  1 = Rs.10 coin, 0 = Rs.5 coin (meaningful with coin_valid_o)
//   coin_ack_i     hopper has taken the offered coin
//   done_o         one-cycle pulse at the end of a request
//   short_o        qualifies done_o: 1 = payout incomplete
//   residue_o      unpaid amount, held until the next done_o
//   cnt10_o        current Rs.10 inventory
//   cnt5_o         current Rs.5 inventory
module vend_change_dispenser #(
  parameter int unsigned COIN10_INIT = 8,
  parameter int unsigned COIN5_INIT  = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid_i,
  input  logic [4:0]       req_amount_i,
  output logic             req_ready_o,
  input  logic             refill_i,
  output logic             coin_valid_o,
  output logic             coin_is_ten_o,
  input  logic             coin_ack_i,
  output logic             done_o,
  output logic             short_o,
  output logic [4:0]       residue_o,
  output logic [CNT_W-1:0] cnt10_o,
  output logic [CNT_W-1:0] cnt5_o
);

  localparam logic [CNT_W-1:0] Cnt10Init = CNT_W'(COIN10_INIT);
  localparam logic [CNT_W-1:0] Cnt5Init  = CNT_W'(COIN5_INIT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StSelect, StPay, StFinish} state_e;

  state_e           state_q, state_d;
  logic [4:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] cnt10_q, cnt10_d;
  logic [CNT_W-1:0] cnt5_q, cnt5_d;
  logic             ten_q, ten_d;
  logic             short_q, short_d;
  logic [4:0]       residue_q, residue_d;

`ifdef VEND_ACK_TIMEOUT_EN
  // wdog_q counts the PAY cycles already spent waiting. When the 15th waiting
  // cycle ends without an ack, the wait is abandoned.
  localparam logic [3:0] WdogLast = 4'd14;
  logic [3:0] wdog_q, wdog_d;
`endif

  // A denomination is chosen only when it fits the remaining amount and is in stock.
  logic fit10, fit5;
  assign fit10 = (remaining_q >= 5'd10) && (cnt10_q != '0);
  assign fit5  = (remaining_q >= 5'd5) && (cnt5_q != '0);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt10_q     <= Cnt10Init;
      cnt5_q      <= Cnt5Init;
      ten_q       <= 1'b0;
      short_q     <= 1'b0;
      residue_q   <= '0;
`ifdef VEND_ACK_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt10_q     <= cnt10_d;
      cnt5_q      <= cnt5_d;
      ten_q       <= ten_d;
      short_q     <= short_d;
      residue_q   <= residue_d;
`ifdef VEND_ACK_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt10_d     = cnt10_q;
    cnt5_d      = cnt5_q;
    ten_d       = ten_q;
    short_d     = short_q;
    residue_d   = residue_q;
`ifdef VEND_ACK_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    unique case (state_q)
      StIdle: begin
        // A refill takes priority, and req_ready_o is low while it is asserted.
        if (refill_i) begin
          cnt10_d = Cnt10Init;
          cnt5_d  = Cnt5Init;
        end else if (req_valid_i) begin
          remaining_d = req_amount_i;
          state_d     = StSelect;
        end
      end

      StSelect: begin
        if (fit10) begin
          ten_d   = 1'b1;
          state_d = StPay;
        end else if (fit5) begin
          ten_d   = 1'b0;
          state_d = StPay;
        end else begin
          short_d   = (remaining_q != '0);
          residue_d = remaining_q;
          state_d   = StFinish;
        end
`ifdef VEND_ACK_TIMEOUT_EN
        wdog_d = '0;
`endif
      end

      StPay: begin
        if (coin_ack_i) begin
          if (ten_q) begin
            remaining_d = remaining_q - 5'd10;
            cnt10_d     = cnt10_q - CntOne;
          end else begin
            remaining_d = remaining_q - 5'd5;
            cnt5_d      = cnt5_q - CntOne;
          end
          state_d = StSelect;
        end
`ifdef VEND_ACK_TIMEOUT_EN
        else if (wdog_q == WdogLast) begin
          short_d   = 1'b1;
          residue_d = remaining_q;
          state_d   = StFinish;
        end else begin
          wdog_d = wdog_q + 4'd1;
        end
`endif
      end

      StFinish: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o   = (state_q == StIdle) && !refill_i;
    coin_valid_o  = (state_q == StPay);
    coin_is_ten_o = (state_q == StPay) && ten_q;
    done_o        = (state_q == StFinish);
    short_o       = short_q;
    residue_o     = residue_q;
    cnt10_o       = cnt10_q;
    cnt5_o        = cnt5_q;
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Self-checking bench for vend_change_dispenser.
// A transaction-level model plans each payout greedily on acceptance (a queue of
// coins) and tracks inventory, remaining amount and event timing. A compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add hand-computed literal checks on coin counts, residues and latency.
module tb_vend_change_dispenser;

  localparam int unsigned C10 = 8;
  localparam int unsigned C5  = 8;
  localparam int unsigned CW  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [4:0]    req_amount = '0;
  logic          refill = 1'b0;
  logic          coin_ack = 1'b0;
  logic          req_ready_o, coin_valid_o, coin_is_ten_o, done_o, short_o;
  logic [4:0]    residue_o;
  logic [CW-1:0] cnt10_o, cnt5_o;

  vend_change_dispenser #(
    .COIN10_INIT(C10),
    .COIN5_INIT (C5),
    .CNT_W      (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_amount_i (req_amount),
    .req_ready_o  (req_ready_o),
    .refill_i     (refill),
    .coin_valid_o (coin_valid_o),
    .coin_is_ten_o(coin_is_ten_o),
    .coin_ack_i   (coin_ack),
    .done_o       (done_o),
    .short_o      (short_o),
    .residue_o    (residue_o),
    .cnt10_o      (cnt10_o),
    .cnt5_o       (cnt5_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // age = edges since the last event (accept or ack). At age 2, the next coin is
  // offered, or done is shown if nothing is left to pay.
  bit mvalid = 0;
  bit busy = 0;
  int age = 0;
  int q[$];
  int m_cnt10 = 0, m_cnt5 = 0, m_rem = 0, o_res = 0;
  bit o_short = 0;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        mvalid = 1; busy = 0; q.delete();
        m_cnt10 = C10; m_cnt5 = C5; o_short = 0; o_res = 0; m_rem = 0;
      end else if (!busy) begin
        if (refill) begin
          m_cnt10 = C10; m_cnt5 = C5;
        end else if (req_valid) begin
          int r, c10, c5;
          busy = 1; age = 1; m_rem = req_amount; q.delete();
          r = req_amount; c10 = m_cnt10; c5 = m_cnt5;
          while (r >= 10 && c10 > 0) begin q.push_back(10); r -= 10; c10--; end
          while (r >= 5 && c5 > 0) begin q.push_back(5); r -= 5; c5--; end
        end
      end else if (q.size() > 0 && age >= 2) begin
        if (coin_ack) begin
          int take;
          take = q.pop_front();
          m_rem -= take;
          if (take == 10) m_cnt10--; else m_cnt5--;
          age = 1;
        end
`ifdef VEND_ACK_TIMEOUT_EN
        else if (age == 16) begin
          q.delete(); age = 2; o_short = 1; o_res = m_rem;
        end
`endif
        else age++;
      end else if (q.size() == 0 && age >= 2) begin
        busy = 0;
      end else begin
        age++;
        if (age == 2 && q.size() == 0) begin
          o_short = (m_rem != 0); o_res = m_rem;
        end
      end
    end
  end

  // ---------------- compare + monitors ----------------
  int n_ten = 0, n_five = 0, n_cv = 0, n_done = 0;
  logic last_short;
  logic [4:0] last_res;

  initial begin
    forever begin
      @(negedge clock);
      if (mvalid) begin
        bit ecv, edone, eten;
        ecv   = busy && age >= 2 && q.size() > 0;
        edone = busy && age >= 2 && q.size() == 0;
        eten  = 0;
        if (ecv) eten = (q[0] == 10);
        chk("req_ready", req_ready_o, !busy && !refill);
        chk("coin_valid", coin_valid_o, ecv);
        chk("coin_is_ten", coin_is_ten_o, eten);
        chk("done", done_o, edone);
        chk("short", short_o, o_short);
        chk("residue", residue_o, o_res);
        chk("cnt10", cnt10_o, m_cnt10);
        chk("cnt5", cnt5_o, m_cnt5);
      end
      if (done_o === 1'b1) begin
        last_short = short_o; last_res = residue_o; n_done++;
      end
      if (coin_valid_o === 1'b1) begin
        n_cv++;
        if (coin_ack === 1'b1) begin
          if (coin_is_ten_o) n_ten++; else n_five++;
        end
      end
    end
  end

  // ---------------- hopper ----------------
  // Acks after ack_wait cycles of coin_valid; ack_budget < 0 means acks are unlimited.
  int ack_wait = 1;
  int ack_budget = -1;
  bit stray_ack = 0;

  initial begin
    int run;
    run = 0;
    forever begin
      @(posedge clock); #1;
      if (coin_valid_o === 1'b1) begin
        run++;
        if (run > ack_wait && ack_budget != 0) begin
          coin_ack = 1'b1;
          if (ack_budget > 0) ack_budget--;
        end else coin_ack = 1'b0;
      end else begin
        run = 0;
        coin_ack = stray_ack;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int amt, output bit acc);
    acc = 0;
    req_valid = 1'b1; req_amount = amt[4:0];
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clock); acc = req_ready_o;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // lat counts the accept cycle, then each following cycle up to and including done.
  task automatic do_req(input int amt, output int lat);
    bit acc, got;
    lat = 0; got = 0;
    n_ten = 0; n_five = 0; n_cv = 0;
    send(amt, acc);
    if (acc) begin
      lat = 1;
      for (int n = 0; n < 300 && !got; n++) begin
        @(negedge clock); lat++;
        got = (done_o === 1'b1);
      end
      if (!got) chk("done_timeout", 0, 1);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int lat, nd;
    bit acc, hit;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_cnt10", cnt10_o, 8);
    chk("rst_cnt5", cnt5_o, 8);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_residue", residue_o, 0);
    @(posedge clock); #1;

    // 20 with full stock: two Rs.10 coins
    do_req(20, lat);
    chk("r20_tens", n_ten, 2);
    chk("r20_fives", n_five, 0);
    chk("r20_short", last_short, 0);
    chk("r20_res", last_res, 0);
    chk("r20_cnt10", cnt10_o, 6);
    chk("r20_cnt5", cnt5_o, 8);

    // drain the tens
    do_req(30, lat);
    do_req(30, lat);
    chk("drain_cnt10", cnt10_o, 0);

    // 15 with no tens: three fives
    do_req(15, lat);
    chk("r15_fives", n_five, 3);
    chk("r15_tens", n_ten, 0);
    chk("r15_short", last_short, 0);
    chk("r15_cnt5", cnt5_o, 5);

    // 7: one five, residue 2
    do_req(7, lat);
    chk("r7_fives", n_five, 1);
    chk("r7_short", last_short, 1);
    chk("r7_res", last_res, 2);

    // 0: no coins, accept/select/finish = 3 cycles
    do_req(0, lat);
    chk("r0_lat", lat, 3);
    chk("r0_coins", n_ten + n_five, 0);
    chk("r0_short", last_short, 0);
    chk("r0_res", last_res, 0);

    // refill with a request pending: refill wins, no accept
    refill = 1'b1; req_valid = 1'b1; req_amount = 5'd10;
    repeat (2) @(posedge clock);
    #1 refill = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk("refill_cnt10", cnt10_o, 8);
    chk("refill_cnt5", cnt5_o, 8);
    chk("refill_ready", req_ready_o, 1);
    @(posedge clock); #1;

    // bring stock to 1/1
    do_req(30, lat);
    do_req(30, lat);
    do_req(10, lat);
    for (int i = 0; i < 7; i++) do_req(5, lat);
    chk("pre25_cnt10", cnt10_o, 1);
    chk("pre25_cnt5", cnt5_o, 1);

    // 25 with 1/1: ten then five, residue 10
    do_req(25, lat);
    chk("r25_tens", n_ten, 1);
    chk("r25_fives", n_five, 1);
    chk("r25_short", last_short, 1);
    chk("r25_res", last_res, 10);
    chk("r25_cnt10", cnt10_o, 0);
    chk("r25_cnt5", cnt5_o, 0);

    refill = 1'b1; @(posedge clock); #1 refill = 1'b0;

    // ack while idle is ignored
    stray_ack = 1'b1;
    repeat (3) @(posedge clock);
    #1 stray_ack = 1'b0;
    @(negedge clock);
    chk("stray_cnt10", cnt10_o, 8);
    chk("stray_cnt5", cnt5_o, 8);
    @(posedge clock); #1;

    // 30: first coin acked, second withheld, reset in its second PAY cycle
    nd = n_done;
    ack_budget = 1;
    send(30, acc);
    hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clock);
      hit = (coin_valid_o === 1'b1) && (cnt10_o == 7);
    end
    if (!hit) chk("second_coin_timeout", 0, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    ack_budget = -1;
    @(negedge clock);
    chk("abort_cv", coin_valid_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ready", req_ready_o, 1);
    chk("abort_cnt10", cnt10_o, 8);
    chk("abort_cnt5", cnt5_o, 8);
    chk("abort_short", short_o, 0);
    chk("abort_res", residue_o, 0);
    chk("abort_no_done", n_done, nd);
    @(posedge clock); #1;

    // a new request is accepted after the abort
    do_req(10, lat);
    chk("post_tens", n_ten, 1);
    chk("post_short", last_short, 0);
    chk("post_cnt10", cnt10_o, 7);

`ifdef VEND_ACK_TIMEOUT_EN
    // hopper never acks: watchdog gives up after 15 offered cycles
    ack_budget = 0;
    do_req(10, lat);
    ack_budget = -1;
    chk("wd_cv_cycles", n_cv, 15);
    chk("wd_short", last_short, 1);
    chk("wd_res", last_res, 10);
    chk("wd_cnt10", cnt10_o, 7);
`endif

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
